// File: rtl/fir_pkg.sv
// Shared constants and parameter sanity helper for the FIR output decimator
// slice.
//   Y_W            : width of a FIR output sample (unsigned 0..3)
//   DECIM_DEF      : default number of samples summed per output word
//   ACC_W_DEF      : default accumulator / output word width
//   FIFO_DEPTH_DEF : default output FIFO depth
//   acc_w_ok()     : true when an accumulator width holds a full block sum
package fir_pkg;

   localparam int unsigned Y_W            = 2;
   localparam int unsigned DECIM_DEF      = 4;
   localparam int unsigned ACC_W_DEF      = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 4;

   // Largest block sum is 3*decim < 4*decim, so 2+clog2(decim) bits always suffice.
   function automatic bit acc_w_ok(input int unsigned decim, input int unsigned acc_w);
      return acc_w >= (2 + $clog2(decim));
   endfunction

endpackage

// File: rtl/fir_output_decimator_if.sv
// Sample input, output word handshake and status bundle of the decimator.
//   y_in/y_valid          : FIR sample stream into the decimator
//   out_data/out_valid    : oldest buffered block sum
//   out_ready             : consumer accepts out_data
//   clr_ovf/ovf           : sticky overflow clear / flag
//   fill                  : output FIFO occupancy
// Modport slave is the decimator side, master is the producer/consumer side.
interface fir_output_decimator_if
   import fir_pkg::*;
#(
   parameter int unsigned ACC_W      = ACC_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
);
   localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;

   logic [Y_W-1:0]    y_in;
   logic              y_valid;
   logic              clr_ovf;
   logic [ACC_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic              ovf;
   logic [FILL_W-1:0] fill;

   modport slave (
      input  y_in, y_valid, clr_ovf, out_ready,
      output out_data, out_valid, ovf, fill
   );

   modport master (
      output y_in, y_valid, clr_ovf, out_ready,
      input  out_data, out_valid, ovf, fill
   );

endinterface

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with registered head-of-queue read data.
//   clk, rst   : clock, synchronous active-low reset
//   wr_en_i    : push request (ignored when full unless popping the same cycle)
//   wr_data_i  : push data
//   rd_en_i    : pop request (ignored when empty)
//   rd_data_o  : oldest entry, zero when empty
//   full_o, empty_o, fill_o : occupancy status
module fir_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   fill_o
);
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned FILL_W = PTR_W + 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [WIDTH-1:0]  head_q, head_d;
   logic              do_push, do_pop, full, empty;

   assign empty = (fill_q == '0);
   assign full  = (fill_q == FILL_W'(DEPTH));

   always_comb begin
      do_pop   = rd_en_i & ~empty;
      do_push  = wr_en_i & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      head_d   = head_q;

      // Pointers are power-of-two wide, so wrap is the natural overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({do_push, do_pop})
         2'b10:   fill_d = fill_q + FILL_W'(1);
         2'b01:   fill_d = fill_q - FILL_W'(1);
         default: fill_d = fill_q;
      endcase

      // Head register tracks what the entry at the next read pointer will be,
      // including the bypass when the pushed word becomes the new head.
      if (do_pop) begin
         if (fill_q == FILL_W'(1)) head_d = do_push ? wr_data_i : '0;
         else                      head_d = mem_q[rd_ptr_q + PTR_W'(1)];
      end else if (empty && do_push) begin
         head_d = wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = head_q;
   assign full_o    = full;
   assign empty_o   = empty;
   assign fill_o    = fill_q;

endmodule

// File: rtl/fir_output_decimator.sv
// Sums every DECIM valid FIR samples into one block word and buffers the
// words in an output FIFO with a ready/valid handshake.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of fir_output_decimator_if (samples in, words out,
//              sticky overflow flag with clear, FIFO fill level)
module fir_output_decimator
   import fir_pkg::*;
#(
   parameter int unsigned DECIM      = DECIM_DEF,
   parameter int unsigned ACC_W      = ACC_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   fir_output_decimator_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(DECIM);

   if (!acc_w_ok(DECIM, ACC_W)) begin : g_bad_acc_w
      $error("ACC_W too narrow for DECIM");
   end

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] sum;
   logic             sum_valid;
   logic             drop;
   logic             fifo_full, fifo_empty;

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sum_valid = 1'b0;
      sum       = acc_q + ACC_W'(bus.y_in);
      if (bus.y_valid) begin
         if (cnt_q == CNT_W'(DECIM - 1)) begin
            sum_valid = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // A full FIFO is never empty, so a pop happens exactly when out_ready is high.
   always_comb begin
      drop  = sum_valid & fifo_full & ~bus.out_ready;
      ovf_d = ovf_q;
      if (drop)             ovf_d = 1'b1;
      else if (bus.clr_ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   fir_sync_fifo #(
      .WIDTH (ACC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (sum_valid),
      .wr_data_i (sum),
      .rd_en_i   (bus.out_ready),
      .rd_data_o (bus.out_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .fill_o    (bus.fill)
   );

   assign bus.out_valid = ~fifo_empty;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed and randomized checks of fir_output_decimator against a
// queue-based reference model of block summing and output buffering.
module tb_fir_output_decimator;
   localparam int unsigned DECIM = 4;
   localparam int unsigned ACC_W = 8;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fir_output_decimator_if #(.ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)) bus ();

   fir_output_decimator #(
      .DECIM      (DECIM),
      .ACC_W      (ACC_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   int mq[$];
   int macc = 0;
   int mcnt = 0;
   bit movf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      int exp_data;
      exp_data = (mq.size() > 0) ? mq[0] : 0;
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("out_data",  32'(bus.out_data),  32'(exp_data));
      chk("fill",      32'(bus.fill),      32'(mq.size()));
      chk("ovf",       32'(bus.ovf),       32'(movf));
   endtask

   // One clock: drive inputs, advance model with the values sampled at the
   // edge, then compare every output just after the edge.
   task automatic cyc(input bit r, input bit v, input int y, input bit rdy, input bit clr);
      bit pop, have, drop;
      int s;
      rst         = r;
      bus.y_valid = v;
      bus.y_in    = 2'(y);
      bus.out_ready = rdy;
      bus.clr_ovf = clr;
      @(posedge clk);
      if (!r) begin
         mq.delete();
         macc = 0;
         mcnt = 0;
         movf = 1'b0;
      end else begin
         pop  = rdy && (mq.size() > 0);
         have = 1'b0;
         s    = 0;
         if (v) begin
            if (mcnt == DECIM - 1) begin
               have = 1'b1;
               s    = macc + y;
               macc = 0;
               mcnt = 0;
            end else begin
               macc += y;
               mcnt++;
            end
         end
         drop = have && (mq.size() == DEPTH) && !pop;
         if (pop) void'(mq.pop_front());
         if (have && !drop) mq.push_back(s);
         if (drop) movf = 1'b1;
         else if (clr) movf = 1'b0;
      end
      #1;
      check_model();
   endtask

   initial begin
      bus.y_in = '0; bus.y_valid = 1'b0; bus.out_ready = 1'b0; bus.clr_ovf = 1'b0;

      // Reset with noisy inputs: everything stays zero
      cyc(0, 1, 3, 1, 1);
      cyc(0, 1, 3, 1, 1);
      chk("rst_data", 32'(bus.out_data), 0);
      chk("rst_fill", 32'(bus.fill), 0);

      // Basic block 3,2,1,0 -> 6 for one cycle
      cyc(1, 1, 3, 1, 0);
      cyc(1, 1, 2, 1, 0);
      cyc(1, 1, 1, 1, 0);
      cyc(1, 1, 0, 1, 0);
      chk("blk_sum6", 32'(bus.out_data), 6);
      cyc(1, 0, 0, 1, 0);
      chk("blk_once", 32'(bus.out_valid), 0);

      // Gaps in y_valid are ignored
      cyc(1, 1, 1, 1, 0);
      cyc(1, 0, 3, 1, 0);
      cyc(1, 1, 2, 1, 0);
      cyc(1, 0, 3, 1, 0);
      cyc(1, 1, 3, 1, 0);
      cyc(1, 1, 3, 1, 0);
      chk("gap_sum9", 32'(bus.out_data), 9);
      cyc(1, 0, 0, 1, 0);

      // Backpressure: five blocks of 12, fifth dropped
      for (int i = 0; i < 20; i++) cyc(1, 1, 3, 0, 0);
      chk("full_fill", 32'(bus.fill), 4);
      chk("full_ovf", 32'(bus.ovf), 1);
      for (int i = 0; i < 4; i++) begin
         chk("drain12", 32'(bus.out_data), 12);
         cyc(1, 0, 0, 1, 0);
      end
      chk("drained", 32'(bus.out_valid), 0);

      // Clear ovf alone
      cyc(1, 0, 0, 0, 1);
      chk("clr_ovf", 32'(bus.ovf), 0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 19; i++) cyc(1, 1, $urandom_range(0, 3), 0, 0);
      cyc(1, 1, 2, 1, 0);
      chk("pp_fill", 32'(bus.fill), 4);
      chk("pp_ovf", 32'(bus.ovf), 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0);

      // Reset mid-block discards partial sum
      cyc(1, 1, 3, 1, 0);
      cyc(1, 1, 2, 1, 0);
      cyc(0, 1, 3, 1, 1);
      chk("mid_rst_valid", 32'(bus.out_valid), 0);
      cyc(0, 1, 3, 1, 1);
      for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0);
      chk("post_rst_sum4", 32'(bus.out_data), 4);
      cyc(1, 0, 0, 1, 0);

      // Drop and clear in the same cycle: set wins
      for (int i = 0; i < 19; i++) cyc(1, 1, 3, 0, 0);
      cyc(1, 1, 3, 0, 1);
      chk("set_wins", 32'(bus.ovf), 1);
      cyc(1, 0, 0, 0, 1);
      chk("clr_next", 32'(bus.ovf), 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 63) != 0),
             ($urandom_range(0, 3) != 0),
             $urandom_range(0, 3),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 15) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/fir_output_decimator.md
FIR_OUTPUT_DECIMATOR -- requirements
Module: fir_output_decimator

Interface
REQ-001 Parameter DECIM, default 4: number of valid FIR output samples summed per output word; legal range 2..16.
REQ-002 Parameter ACC_W, default 8: accumulator and output width; shall be at least 2+clog2(DECIM).
REQ-003 Parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 y_in  input  2  FIR filter output sample, unsigned 0..3.
REQ-007 y_valid  input  1  y_in is a valid sample this cycle.
REQ-008 clr_ovf  input  1  clears the sticky overflow flag.
REQ-009 out_data  output  ACC_W  oldest buffered block sum.
REQ-010 out_valid  output  1  out_data holds a valid word (FIFO not empty).
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 ovf  output  1  sticky flag: a completed block sum was dropped.
REQ-013 fill  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 The block shall hold an accumulator acc (ACC_W bits) and a sample counter cnt (0..DECIM-1).
REQ-015 When y_valid=1 and cnt<DECIM-1: acc<=acc+y_in (zero-extended) and cnt<=cnt+1.
REQ-016 When y_valid=1 and cnt=DECIM-1: block sum acc+y_in is pushed to the FIFO, acc<=0, and cnt<=0 in the same cycle.
REQ-017 When y_valid=0: acc and cnt shall hold.
REQ-018 Block sums shall never wrap; the maximum sum is 3*DECIM, which fits in ACC_W by REQ-002.
REQ-019 Push latency: a sum completed in cycle N shall be visible on out_data/out_valid in cycle N+1 if the FIFO was empty.
REQ-020 A word transfers when out_valid=1 and out_ready=1; out_data shall advance to the next entry in the following cycle.
REQ-021 out_data shall be stable while out_valid=1 and out_ready=0.
REQ-022 FIFO empty: out_valid=0 and out_data=0; out_ready is ignored.
REQ-023 FIFO full with a push and no pop: the sum is dropped, ovf<=1, and FIFO contents are unchanged; acc and cnt still restart per REQ-016.
REQ-024 FIFO full with a simultaneous push and pop: both shall be performed, fill stays at FIFO_DEPTH, and ovf is unchanged.
REQ-025 FIFO empty with a simultaneous push and pop: the pop is ignored and the push is accepted.
REQ-026 Read and write pointers shall wrap modulo FIFO_DEPTH.
REQ-027 clr_ovf=1 shall clear ovf next cycle; if a drop occurs in the same cycle, set wins and ovf stays 1.

Reset
REQ-028 While rst=0 at posedge clk: acc=0, cnt=0, FIFO pointers=0, fill=0, out_valid=0, out_data=0, ovf=0.
REQ-029 Reset asserted mid-block shall discard the partial sum; the first valid sample after rst returns to 1 starts a new block at cnt=0.
REQ-030 y_valid, out_ready and clr_ovf shall be ignored while rst=0.

Structure
REQ-031 Shared package fir_pkg shall hold Y_W=2, DECIM_DEF=4, ACC_W_DEF=8, FIFO_DEPTH_DEF=4 and a width-check function for the ACC_W rule.
REQ-032 The FIFO shall be a separate sub-module fir_sync_fifo (parameterised width/depth, registered read data, full/empty/fill).
REQ-033 The accumulate/count logic shall reside in fir_output_decimator; no latches, and no combinational path from out_ready to out_valid.

Verification
REQ-034 DECIM=4; y_in=3,2,1,0 with y_valid=1, out_ready=1 -> out_data=6, out_valid=1 for exactly one cycle, one cycle after the 4th sample.
REQ-035 y_valid pattern 1,0,1,0,1,1 carrying y_in=1,x,2,x,3,3 -> a single output word 9; invalid cycles have no effect.
REQ-036 out_ready=0, y_in=3 valid every cycle for 20 cycles -> FIFO holds four words of 12, fill=4, ovf=1 after the 5th block; raising out_ready then drains 12,12,12,12 in order.
REQ-037 FIFO full, push and pop in the same cycle -> fill stays 4, ovf unchanged, the next word is correct.
REQ-038 rst=0 after 2 of 4 samples (sum 5), then y_in=1 four times -> output 4, not 9; all outputs zero during reset.
REQ-039 clr_ovf=1 in the same cycle as a drop -> ovf stays 1; clr_ovf=1 alone -> ovf=0 next cycle.
